// File: rtl/guineveer_rst_sequencer.sv
// guineveer_rst_sequencer: staged multi-domain reset release with per-domain synchronisers,
// software re-sequence, sticky cycle watchdog and saturating cycle counter.
module guineveer_rst_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int STAGE_DELAY = 3,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYCLES = 100_000_000,
  parameter int CNT_W       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_DOMAINS-1:0] dom_clk_i,
  input  logic                   sw_rst_req_i,
  input  logic                   wdog_en_i,
  input  logic                   wdog_kick_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_no,
  output logic                   seq_done_o,
  output logic                   wdog_timeout_o,
  output logic [CNT_W-1:0]       cycle_cnt_o
);
  localparam int STW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam int DW  = STAGE_DELAY > 1 ? $clog2(STAGE_DELAY) : 1;
  localparam logic [STW-1:0]   LAST_STAGE = STW'(NUM_DOMAINS - 1);
  localparam logic [DW-1:0]    LAST_DLY   = DW'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] WDOG_LIM   = CNT_W'(WDOG_CYCLES);

  typedef enum logic {SEQ, DONE} state_t;

  state_t                 state_q, state_d;
  logic [STW-1:0]         stage_q, stage_d;
  logic [DW-1:0]          dly_q, dly_d;
  logic [NUM_DOMAINS-1:0] rel_q, rel_d;
  logic                   done_d;
  logic [CNT_W-1:0]       wdog_q;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    dly_d   = dly_q;
    rel_d   = rel_q;
    if (sw_rst_req_i) begin
      state_d = SEQ;
      stage_d = '0;
      dly_d   = '0;
      rel_d   = '0;
    end else if (state_q == SEQ) begin
      if (dly_q == LAST_DLY) begin
        rel_d   = rel_q | (NUM_DOMAINS'(1) << stage_q);
        dly_d   = '0;
        stage_d = stage_q == LAST_STAGE ? '0 : stage_q + 1'b1;
        state_d = stage_q == LAST_STAGE ? DONE : SEQ;
      end else begin
        dly_d = dly_q + 1'b1;
      end
    end
    done_d = !sw_rst_req_i && state_q == DONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SEQ;
      stage_q    <= '0;
      dly_q      <= '0;
      rel_q      <= '0;
      seq_done_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      dly_q      <= dly_d;
      rel_q      <= rel_d;
      seq_done_o <= done_d;
    end
  end

  // Once expired the count freezes; only rst_ni clears the flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q         <= '0;
      wdog_timeout_o <= 1'b0;
    end else if (wdog_kick_i || sw_rst_req_i) begin
      wdog_q <= '0;
    end else if (wdog_en_i && state_q == DONE && !wdog_timeout_o) begin
      wdog_q <= wdog_q + 1'b1;
      if (wdog_q + 1'b1 == WDOG_LIM) wdog_timeout_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycle_cnt_o <= '0;
    else if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + 1'b1;
  end

  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_sync
    logic                   arst_n;
    logic [SYNC_STAGES-1:0] ff;
    assign arst_n = rst_ni & rel_q[k];
    always_ff @(posedge dom_clk_i[k] or negedge arst_n) begin
      if (!arst_n) ff <= '0;
      else ff <= {ff[SYNC_STAGES-2:0], 1'b1};
    end
    assign dom_rst_no[k] = ff[SYNC_STAGES-1];
  end
endmodule

// File: tb/tb_guineveer_rst_sequencer.sv
// tb_guineveer_rst_sequencer: edge-count model of the release schedule and watchdog,
// checked every clk_i cycle, plus directed literal checks of the documented scenarios.
`timescale 1ns/1ps
module tb_guineveer_rst_sequencer;
  localparam int N = 3, SD = 3, SS = 2, WD = 20;

  logic clk = 0, fast = 0, slow = 0;
  logic rst_n = 1, sw = 0, en = 0, kick = 0;
  logic [2:0] dom_a = 0, dom_b;
  logic [2:0] dra, drb;
  logic done_a, done_b, to_a, to_b;
  logic [31:0] cc_a;
  logic [3:0] cc_b;

  int pass_n = 0, tot_n = 0;
  int edge_n = 0, seq_e = 0, wc = 0, ord_k = 0;
  logic m_to = 0, ord_on = 0;
  bit dn;
  logic [2:0] e_dr;

  assign dom_b = {slow, fast, slow};

  guineveer_rst_sequencer #(.NUM_DOMAINS(N), .STAGE_DELAY(SD), .SYNC_STAGES(SS),
    .WDOG_CYCLES(WD), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .dom_clk_i(dom_a), .sw_rst_req_i(sw), .wdog_en_i(en),
    .wdog_kick_i(kick), .dom_rst_no(dra), .seq_done_o(done_a), .wdog_timeout_o(to_a),
    .cycle_cnt_o(cc_a));

  guineveer_rst_sequencer #(.NUM_DOMAINS(N), .STAGE_DELAY(SD), .SYNC_STAGES(SS),
    .WDOG_CYCLES(10), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .dom_clk_i(dom_b), .sw_rst_req_i(sw), .wdog_en_i(en),
    .wdog_kick_i(kick), .dom_rst_no(drb), .seq_done_o(done_b), .wdog_timeout_o(to_b),
    .cycle_cnt_o(cc_b));

  // 25 MHz sequencer clock; DUT A domains share it, DUT B uses 250 MHz / 33.33 MHz.
  always #20 begin
    clk = ~clk;
    dom_a = {3{clk}};
  end
  always #2 fast = ~fast;
  always #15 slow = ~slow;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
  endtask

  // Model: seq_e counts clk_i edges since the sequence (re)started.
  always @(posedge clk) begin
    if (!rst_n) begin
      edge_n = 0;
      seq_e = 0;
      wc = 0;
      m_to = 0;
    end else begin
      dn = seq_e >= N * SD;
      edge_n++;
      if (sw) begin
        seq_e = 0;
        wc = 0;
      end else begin
        if (kick) wc = 0;
        else if (en && dn && !m_to) begin
          wc++;
          if (wc == WD) m_to = 1;
        end
        if (seq_e < 1000) seq_e++;
      end
    end
    #1;
    for (int k = 0; k < N; k++) e_dr[k] = seq_e >= (k + 1) * SD + SS;
    chk("dom_rst_no", dra, e_dr);
    chk("seq_done", done_a, seq_e >= N * SD + 1);
    chk("wdog_timeout", to_a, m_to);
    chk("cycle_cnt", cc_a, edge_n);
    chk("cycle_cnt_sat", cc_b, edge_n > 15 ? 15 : edge_n);
  end

  // Mixed-clock release: each change must extend the released prefix by one domain.
  always @(drb) begin
    if (ord_on && rst_n) begin
      logic [3:0] m;
      ord_k++;
      m = (4'd1 << ord_k) - 4'd1;
      chk("release_order", drb, m[2:0]);
    end
  end

  task automatic wait_edge(input int n);
    int g = 0;
    while (edge_n < n && g < 500) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (g >= 500) begin
      tot_n++;
      $display("FAIL wait_edge: reached edge %0d, required %0d", edge_n, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    sw = 0;
    kick = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #5 rst_n = 0;
    #1;
    chk("reset_dom_rst", dra, 3'b000);
    chk("reset_done", done_a, 0);
    chk("reset_timeout", to_a, 0);
    chk("reset_cnt", cc_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    // Plain release: 5/8/11, done at 10.
    wait_edge(4);  chk("t1_e4", dra, 3'b000);
    wait_edge(5);  chk("t1_e5", dra, 3'b001);
    wait_edge(8);  chk("t1_e8", dra, 3'b011);
    wait_edge(9);  chk("t1_done9", done_a, 0);
    wait_edge(10); chk("t1_done10", done_a, 1);
    wait_edge(11); chk("t1_e11", dra, 3'b111);
    // Software request at edge 7 only.
    do_reset();
    wait_edge(6);
    @(negedge clk) sw = 1;
    wait_edge(7);  chk("t2_e7", dra, 3'b000);
    @(negedge clk) sw = 0;
    wait_edge(11); chk("t2_e11", dra, 3'b000);
    wait_edge(12); chk("t2_e12", dra, 3'b001);
    wait_edge(16); chk("t2_done16", done_a, 0);
    wait_edge(17); chk("t2_done17", done_a, 1);
    chk("t2_cnt17", cc_a, 17);
    // Watchdog expiry, sticky across time and a software request.
    do_reset();
    en = 1;
    wait_edge(28); chk("t3_to28", to_a, 0);
    wait_edge(29); chk("t3_to29", to_a, 1);
    wait_edge(129);
    @(negedge clk) sw = 1;
    @(negedge clk) sw = 0;
    wait_edge(135); chk("t3_sticky", to_a, 1);
    // Kick on the edge that would expire.
    do_reset();
    wait_edge(1);  chk("t4_cleared", to_a, 0);
    wait_edge(28);
    @(negedge clk) kick = 1;
    wait_edge(29); chk("t4_kick29", to_a, 0);
    @(negedge clk) kick = 0;
    wait_edge(48); chk("t4_to48", to_a, 0);
    wait_edge(49); chk("t4_to49", to_a, 1);
    // Asynchronous reset mid-sequence.
    en = 0;
    do_reset();
    wait_edge(4);
    chk("t5_cnt4", cc_a, 4);
    @(negedge clk) rst_n = 0;
    #1;
    chk("t5_async_dom", dra, 3'b000);
    chk("t5_async_done", done_a, 0);
    chk("t5_async_cnt", cc_a, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1;
    wait_edge(10); chk("t5_done10", done_a, 1);
    wait_edge(11); chk("t5_e11", dra, 3'b111);
    // Mixed domain clocks and 4-bit counter saturation.
    do_reset();
    wait_edge(1);
    ord_on = 1;
    wait_edge(40);
    ord_on = 0;
    chk("t6_released", drb, 3'b111);
    chk("t6_order_steps", ord_k, 3);
    chk("t6_sat", cc_b, 15);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end
endmodule
